// File: rtl/scm_refill_pkg.sv
// Shared types and constants for the SCM refill writer.
// The LFSR seed/taps are only consumed when SCM_REFILL_LFSR_EN is defined.
package scm_refill_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1, maximal length
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/scm_refill_fifo.sv
// Small request buffer: push on in_valid when not full, pop from head on pop.
// Pointers carry one extra wrap bit to tell full from empty.
module scm_refill_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             pop,
  output logic [WIDTH-1:0] out_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push     = in_valid && !full;
  assign do_pop   = pop && !empty;
  assign out_data = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/scm_refill_writer.sv
// Drives the write port of a multi-way latch register file from a buffered refill
// request stream, plus a full-array flush. Define SCM_REFILL_LFSR_EN for LFSR victims.
module scm_refill_writer
  import scm_refill_pkg::*;
#(
  parameter int NB_WAYS    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic [NB_WAYS-1:0]    req_way_i,
  input  logic                  flush_i,
  output logic                  WriteEnable,
  output logic [NB_WAYS-1:0]    WriteWay,
  output logic [ADDR_WIDTH-1:0] WriteAddr,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  wr_done_o,
  output logic [ADDR_WIDTH-1:0] wr_done_addr_o,
  output logic                  flush_done_o,
  output logic                  busy_o
);
  localparam int VW = (NB_WAYS > 1) ? $clog2(NB_WAYS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [NB_WAYS-1:0]    way;
  } req_t;

  req_t push_req, head;
  logic fifo_empty, fifo_full, fifo_pop;

  assign push_req = '{addr: req_addr_i, data: req_data_i, way: req_way_i};

  scm_refill_fifo #(.WIDTH($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (req_valid_i),
    .in_data  (push_req),
    .pop      (fifo_pop),
    .out_data (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                  flush_last_q, last_d;  // registered write is the final flush write
  logic                  req_wr_q, req_wr_d;    // registered write came from a request
  logic                  we_d, use_victim;
  logic [NB_WAYS-1:0]    way_d, victim_oh;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [VW-1:0]         victim_idx;

  // Ready only reflects occupancy so it never loops back from the pop decision
  assign req_ready_o = rst_n && !fifo_full;
  assign busy_o      = !fifo_empty || (state_q == ST_FLUSH);
  assign victim_oh   = NB_WAYS'(1) << victim_idx;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    fifo_pop    = 1'b0;
    use_victim  = 1'b0;
    we_d        = 1'b0;
    way_d       = '0;
    addr_d      = '0;
    data_d      = '0;
    req_wr_d    = 1'b0;
    last_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end else if (!fifo_empty && !flush_last_q) begin
          // hold off one cycle after a flush so the refill lands after flush_done_o
          fifo_pop = 1'b1;
          we_d     = 1'b1;
          req_wr_d = 1'b1;
          addr_d   = head.addr;
          data_d   = head.data;
          if (|head.way) begin
            way_d = head.way;
          end else begin
            way_d      = victim_oh;
            use_victim = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        we_d        = 1'b1;
        way_d       = '1;
        addr_d      = flush_cnt_q;
        flush_cnt_d = flush_cnt_q + ADDR_WIDTH'(1);
        if (flush_cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      flush_cnt_q    <= '0;
      flush_last_q   <= 1'b0;
      req_wr_q       <= 1'b0;
      WriteEnable    <= 1'b0;
      WriteWay       <= '0;
      WriteAddr      <= '0;
      WriteData      <= '0;
      wr_done_o      <= 1'b0;
      wr_done_addr_o <= '0;
      flush_done_o   <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      flush_last_q   <= last_d;
      req_wr_q       <= req_wr_d;
      WriteEnable    <= we_d;
      WriteWay       <= way_d;
      WriteAddr      <= addr_d;
      WriteData      <= data_d;
      wr_done_o      <= req_wr_q;
      wr_done_addr_o <= req_wr_q ? WriteAddr : '0;
      flush_done_o   <= flush_last_q;
    end
  end

`ifdef SCM_REFILL_LFSR_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          lfsr_q <= LFSR_SEED;
    else if (use_victim) lfsr_q <= lfsr_next(lfsr_q);
  end
  assign victim_idx = lfsr_q[VW-1:0];
`else
  logic [VW-1:0] rr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else if (use_victim) begin
      if (rr_q == VW'(NB_WAYS-1)) rr_q <= '0;
      else                        rr_q <= rr_q + VW'(1);
    end
  end
  assign victim_idx = rr_q;
`endif

endmodule

// File: tb/tb_scm_refill_writer.sv
// Randomized bench for scm_refill_writer with a queue-based reference model (round-robin build).
module tb_scm_refill_writer;
  localparam int NB_WAYS    = 4;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int NUM_WORDS  = 2**ADDR_WIDTH;

  logic                  clk, rst_n;
  logic                  req_valid_i, req_ready_o, flush_i;
  logic [ADDR_WIDTH-1:0] req_addr_i, WriteAddr, wr_done_addr_o;
  logic [DATA_WIDTH-1:0] req_data_i, WriteData;
  logic [NB_WAYS-1:0]    req_way_i, WriteWay;
  logic                  WriteEnable, wr_done_o, flush_done_o, busy_o;

  scm_refill_writer #(
    .NB_WAYS(NB_WAYS), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_way_i(req_way_i),
    .flush_i(flush_i), .WriteEnable(WriteEnable), .WriteWay(WriteWay),
    .WriteAddr(WriteAddr), .WriteData(WriteData), .wr_done_o(wr_done_o),
    .wr_done_addr_o(wr_done_addr_o), .flush_done_o(flush_done_o), .busy_o(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (evaluated every falling edge) ----------------
  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [NB_WAYS-1:0]    way;
  } mreq_t;

  mreq_t q[$];
  bit    m_flushing;
  int    m_faddr, m_rr;
  logic  e_we, e_req, e_last, e_done, e_fdone;
  logic [NB_WAYS-1:0]    e_way;
  logic [ADDR_WIDTH-1:0] e_addr, e_daddr;
  logic [DATA_WIDTH-1:0] e_data;
  logic [NB_WAYS-1:0]    ww_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_flushing = 0; m_faddr = 0; m_rr = 0;
      e_we = 0; e_req = 0; e_last = 0; e_done = 0; e_fdone = 0;
      e_way = '0; e_addr = '0; e_daddr = '0; e_data = '0;
    end else begin
      int    sz;
      mreq_t r;
      logic  n_we, n_req, n_last;
      logic [NB_WAYS-1:0]    n_way;
      logic [ADDR_WIDTH-1:0] n_addr;
      logic [DATA_WIDTH-1:0] n_data;
      chk("we", WriteEnable, e_we);
      chk("way", WriteWay, e_way);
      chk("addr", WriteAddr, e_addr);
      chk("data", WriteData, e_data);
      chk("wr_done", wr_done_o, e_done);
      if (e_done) chk("wr_done_addr", wr_done_addr_o, e_daddr);
      chk("flush_done", flush_done_o, e_fdone);
      chk("ready", req_ready_o, q.size() < FIFO_DEPTH);
      chk("busy", busy_o, (q.size() != 0) || m_flushing);
      if (WriteEnable) ww_log.push_back(WriteWay);

      sz = q.size();
      e_done  = e_req;
      e_daddr = e_addr;
      e_fdone = e_last;
      n_we = 0; n_req = 0; n_last = 0; n_way = '0; n_addr = '0; n_data = '0;
      if (m_flushing) begin
        n_we = 1; n_way = '1; n_addr = ADDR_WIDTH'(m_faddr);
        if (m_faddr == NUM_WORDS-1) begin m_flushing = 0; n_last = 1; end
        m_faddr++;
      end else if (flush_i) begin
        m_flushing = 1; m_faddr = 0;
      end else if (sz > 0 && !e_last) begin
        r = q.pop_front();
        n_we = 1; n_req = 1; n_addr = r.addr; n_data = r.data;
        if (r.way != 0) n_way = r.way;
        else begin
          n_way = NB_WAYS'(1 << m_rr);
          m_rr  = (m_rr + 1) % NB_WAYS;
        end
      end
      if (req_valid_i && sz < FIFO_DEPTH) begin
        r.addr = req_addr_i; r.data = req_data_i; r.way = req_way_i;
        q.push_back(r);
      end
      e_we = n_we; e_way = n_way; e_addr = n_addr; e_data = n_data;
      e_req = n_req; e_last = n_last;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d,
                      input logic [NB_WAYS-1:0] w);
    bit acc = 0;
    req_valid_i = 1; req_addr_i = a; req_data_i = d; req_way_i = w;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = req_ready_o;
      tick();
    end
    req_valid_i = 0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic pulse_flush();
    flush_i = 1; tick(); flush_i = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = !busy_o && !WriteEnable && !wr_done_o && !flush_done_o;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int acc, nfw, nfd;
    bit hit;
    rst_n = 0; req_valid_i = 0; flush_i = 0;
    req_addr_i = '0; req_data_i = '0; req_way_i = '0;
    #2;
    chk("rst_we", WriteEnable, 0);
    chk("rst_way", WriteWay, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    tick(); tick();
    rst_n = 1;
    #1 chk("rel_ready", req_ready_o, 1);

    // single explicit-way request
    req_valid_i = 1; req_addr_i = 3; req_data_i = 32'hDEADBEEF; req_way_i = 4'b0010;
    tick();
    req_valid_i = 0;
    tick();
    chk("d1_we", WriteEnable, 1);
    chk("d1_way", WriteWay, 4'b0010);
    chk("d1_addr", WriteAddr, 3);
    chk("d1_data", WriteData, 32'hDEADBEEF);
    tick();
    chk("d1_done", wr_done_o, 1);
    chk("d1_done_addr", wr_done_addr_o, 3);
    wait_idle();

    // round-robin victim build-up
    ww_log.delete();
    for (int i = 0; i < 5; i++) send(ADDR_WIDTH'(i + 8), $urandom, '0);
    wait_idle();
    chk("rr_count", ww_log.size(), 5);
    chk("rr0", ww_log[0], 4'b0001);
    chk("rr1", ww_log[1], 4'b0010);
    chk("rr2", ww_log[2], 4'b0100);
    chk("rr3", ww_log[3], 4'b1000);
    chk("rr4", ww_log[4], 4'b0001);

    // flush and pending head in the same cycle
    req_valid_i = 1; req_addr_i = 17; req_data_i = 32'h1234_5678; req_way_i = 4'b0100;
    tick();
    req_valid_i = 0;
    flush_i = 1; tick(); flush_i = 0;
    nfw = 0; hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (WriteEnable && WriteWay == 4'b1111 && WriteData == 0) nfw++;
      hit = flush_done_o;
      if (!hit) tick();
    end
    if (!hit) chk("flush_timeout", 0, 1);
    chk("flush_writes", nfw, NUM_WORDS);
    chk("fd_cycle_we", WriteEnable, 0);
    tick();
    chk("after_fd_we", WriteEnable, 1);
    chk("after_fd_addr", WriteAddr, 17);
    wait_idle();

    // valid held high while flushing: FIFO fills and back-pressures
    pulse_flush();
    acc = 0;
    req_valid_i = 1; req_addr_i = $urandom; req_data_i = $urandom; req_way_i = $urandom;
    for (int i = 0; i < 10; i++) begin
      if (req_ready_o) begin
        acc++;
        tick();
        req_addr_i = $urandom; req_data_i = $urandom; req_way_i = $urandom;
      end else tick();
    end
    chk("bp_accepts", acc, FIFO_DEPTH);
    chk("bp_ready", req_ready_o, 0);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      hit = flush_done_o;
      if (req_ready_o) begin
        tick();
        req_addr_i = $urandom; req_data_i = $urandom; req_way_i = $urandom;
      end else tick();
    end
    if (!hit) chk("bp_flush_timeout", 0, 1);
    req_valid_i = 0;
    wait_idle();

    // random traffic with occasional flushes
    for (int i = 0; i < 1500; i++) begin
      req_valid_i = ($urandom_range(0, 2) != 0);
      req_addr_i  = $urandom;
      req_data_i  = $urandom;
      req_way_i   = $urandom_range(0, 1) ? NB_WAYS'($urandom) : '0;
      flush_i     = ($urandom_range(0, 99) == 0);
      tick();
    end
    req_valid_i = 0; flush_i = 0;
    wait_idle();

    // reset in the middle of a flush
    send(5'd2, 32'hCAFE_F00D, 4'b0000);
    pulse_flush();
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      hit = WriteEnable && WriteAddr == 10 && WriteWay == 4'b1111;
      if (!hit) tick();
    end
    if (!hit) chk("mid_flush_timeout", 0, 1);
    #3 rst_n = 0;
    #1;
    chk("arst_we", WriteEnable, 0);
    chk("arst_way", WriteWay, 0);
    chk("arst_addr", WriteAddr, 0);
    chk("arst_busy", busy_o, 0);
    tick(); tick();
    rst_n = 1;
    nfd = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (flush_done_o || WriteEnable) nfd++;
    end
    chk("post_rst_quiet", nfd, 0);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_ready", req_ready_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scm_refill_writer.md
SCM_REFILL_WRITER -- requirements
Module: scm_refill_writer

Interface
REQ-001 SHALL have parameter NB_WAYS, default 4, number of ways in the driven register file.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, word address width; NUM_WORDS = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, request buffer entries (power of two, >=2).
REQ-005 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid_i  input  1  refill request valid.
REQ-008 SHALL have port req_ready_o  output  1  refill request accepted when high with valid.
REQ-009 SHALL have port req_addr_i  input  ADDR_WIDTH  target word.
REQ-010 SHALL have port req_data_i  input  DATA_WIDTH  write data.
REQ-011 SHALL have port req_way_i  input  NB_WAYS  explicit way mask; all-zero selects victim way.
REQ-012 SHALL have port flush_i  input  1  pulse: zero every word of every way.
REQ-013 SHALL have port WriteEnable  output  1  register-file write enable.
REQ-014 SHALL have port WriteWay  output  NB_WAYS  register-file way mask.
REQ-015 SHALL have port WriteAddr  output  ADDR_WIDTH  register-file write address.
REQ-016 SHALL have port WriteData  output  DATA_WIDTH  register-file write data.
REQ-017 SHALL have port wr_done_o  output  1  pulse: request write now readable.
REQ-018 SHALL have port wr_done_addr_o  output  ADDR_WIDTH  address of completed write.
REQ-019 SHALL have port flush_done_o  output  1  pulse: flush complete.
REQ-020 SHALL have port busy_o  output  1  FIFO non-empty or flushing.

Function
REQ-021 SHALL buffer accepted requests {addr, data, way} in a FIFO_DEPTH FIFO; req_ready_o = FIFO not full, with no dependence on same-cycle pop.
REQ-022 SHALL register all register-file outputs; an accepted request reaches WriteEnable no earlier than the cycle after acceptance (no bypass).
REQ-023 SHALL issue at most one write per cycle, popping the FIFO head only in state IDLE.
REQ-024 SHALL drive WriteWay = req_way when non-zero (multiple bits allowed), else one-hot(victim pointer).
REQ-025 SHALL advance the victim pointer mod NB_WAYS only on writes that used victim selection.
REQ-026 SHALL drive WriteWay, WriteAddr, WriteData to 0 whenever WriteEnable is low.
REQ-027 SHALL pulse wr_done_o with wr_done_addr_o exactly one cycle after each request-sourced WriteEnable cycle (data sampled at that edge, latched during the next cycle).
REQ-028 SHALL implement FSM states IDLE and FLUSH: IDLE->FLUSH on flush_i; FLUSH->IDLE after address NUM_WORDS-1 is written.
REQ-029 SHALL, in FLUSH, write addresses 0..NUM_WORDS-1 consecutively, one per cycle, WriteWay all ones, WriteData 0, with no wr_done_o pulses.
REQ-030 SHALL pulse flush_done_o the cycle after the final flush write.
REQ-031 SHALL give flush_i priority over a pending FIFO head in the same cycle; FIFO entries are held, not discarded.
REQ-032 SHALL ignore flush_i while in FLUSH; SHALL keep accepting requests into the FIFO during FLUSH.
REQ-033 SHALL not change the victim pointer during FLUSH.

Reset
REQ-034 SHALL, on rst_n low, immediately force: FSM IDLE, FIFO empty, victim pointer 0, all outputs 0 except req_ready_o (1 after reset release).
REQ-035 SHALL abandon any flush or buffered request on reset with no done pulse.

Configuration
REQ-036 SHALL, with SCM_REFILL_LFSR_EN defined, choose the victim way from the low log2(NB_WAYS) bits of an 8-bit Fibonacci LFSR (seed 8'hA5, advanced per victim write); without it, use round-robin (REQ-025).

Structure
REQ-037 SHALL place the FSM state enum, LFSR seed and tap constants in package scm_refill_pkg.
REQ-038 SHALL implement buffering in sub-module scm_refill_fifo (parameterised width/depth, valid/ready in, pop/empty/full out).

Verification
REQ-039 Single request addr 3, data 0xDEADBEEF, way 4'b0010 -> WriteEnable cycle+1, WriteWay 0010; wr_done_o with addr 3 cycle+2.
REQ-040 Four requests way 0 (round-robin build) -> WriteWay 0001, 0010, 0100, 1000 in order; fifth -> 0001.
REQ-041 Valid held high with writes stalled by flush -> req_ready_o low after 2 accepts; resumes after flush_done_o; no request lost.
REQ-042 flush_i with ADDR_WIDTH=5 -> 32 consecutive writes, addr 0..31, WriteWay 1111, data 0; flush_done_o 1 cycle after addr 31.
REQ-043 flush_i and pending request same cycle -> flush first, request written after flush_done_o.
REQ-044 rst_n low mid-flush (addr 10) -> outputs 0 asynchronously; after release, no flush_done_o, FIFO empty.
